// File: rtl/arith_pkg.sv
// Shared arithmetic-library definitions: FSM encoding and step-count derivation.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_steps(input int width, input int bits_per_cycle);
    return width / bits_per_cycle;
  endfunction

endpackage

// File: rtl/full_sub.sv
// Combinational 1-bit full-subtractor cell: d = a - b - bin with borrow-out.
module full_sub (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bo_o
);

  assign d_o  = a_i ^ b_i ^ bin_i;
  assign bo_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor d = a - b - bin, BITS_PER_CYCLE bits per RUN cycle.
// Start accepted in IDLE or DONE; result registers update only when entering DONE.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bo,
  output logic             ovf
);

  localparam int STEPS = calc_steps(WIDTH, BITS_PER_CYCLE);
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

  state_t state_q, state_d;
  logic   accept, step, last;

  logic [WIDTH-1:0] a_q, b_q, res_q, d_q;
  logic [CNT_W-1:0] cnt_q;
  logic             brw_q, bo_q, ovf_q;

  logic [BITS_PER_CYCLE:0]               brw_chain;
  logic [BITS_PER_CYCLE-1:0]             diff;
  logic [WIDTH+BITS_PER_CYCLE-1:0]       res_cat;
  logic [WIDTH-1:0]                      res_shift;

  assign brw_chain[0] = brw_q;

  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_cell
    full_sub u_cell (
      .a_i  (a_q[i]),
      .b_i  (b_q[i]),
      .bin_i(brw_chain[i]),
      .d_o  (diff[i]),
      .bo_o (brw_chain[i+1])
    );
  end

  // Difference bits enter from the MSB side so the LSB lands at bit 0 after STEPS shifts.
  assign res_cat   = {diff, res_q};
  assign res_shift = WIDTH'(res_cat >> BITS_PER_CYCLE);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step    = 1'b0;
    last    = (cnt_q == LAST);
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      brw_q   <= 1'b0;
      res_q   <= '0;
      cnt_q   <= '0;
      d_q     <= '0;
      bo_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q   <= a;
        b_q   <= b;
        brw_q <= bin;
        res_q <= '0;
        cnt_q <= '0;
      end else if (step) begin
        a_q   <= a_q >> BITS_PER_CYCLE;
        b_q   <= b_q >> BITS_PER_CYCLE;
        brw_q <= brw_chain[BITS_PER_CYCLE];
        res_q <= res_shift;
        cnt_q <= cnt_q + CNT_W'(1);
        if (last) begin
          // On the final step the top cell of the chain is the MSB cell.
          d_q   <= res_shift;
          bo_q  <= brw_chain[BITS_PER_CYCLE];
          ovf_q <= brw_chain[BITS_PER_CYCLE] ^ brw_chain[BITS_PER_CYCLE-1];
        end
      end
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign d    = d_q;
  assign bo   = bo_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at BITS_PER_CYCLE 1 and 4 (WIDTH 8).
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst, start1, start4, bin, sel;
  logic [7:0] a, b;

  logic       busy1, done1, bo1, ovf1;
  logic [7:0] d1;
  logic       busy4, done4, bo4, ovf4;
  logic [7:0] d4;

  logic       o_busy, o_done, o_bo, o_ovf;
  logic [7:0] o_d;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a), .b(b), .bin(bin),
    .busy(busy1), .done(done1), .d(d1), .bo(bo1), .ovf(ovf1)
  );

  serial_subtractor #(.WIDTH(8), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a), .b(b), .bin(bin),
    .busy(busy4), .done(done4), .d(d4), .bo(bo4), .ovf(ovf4)
  );

  assign o_busy = sel ? busy4 : busy1;
  assign o_done = sel ? done4 : done1;
  assign o_d    = sel ? d4    : d1;
  assign o_bo   = sel ? bo4   : bo1;
  assign o_ovf  = sel ? ovf4  : ovf1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input logic v);
    if (sel) start4 = v;
    else     start1 = v;
  endtask

  task automatic run_op(input logic s, input logic [7:0] av, input logic [7:0] bv,
                        input logic bv_in, input logic [7:0] ed, input logic ebo,
                        input logic eovf, input int elat, input string tag);
    int lat;
    sel = s;
    a = av; b = bv; bin = bv_in;
    set_start(1'b1);
    tick();
    set_start(1'b0);
    check({tag, "_busy"}, {31'b0, o_busy}, 32'd1);
    lat = 0;
    while (!o_done && lat < 40) begin
      tick();
      lat++;
      if (o_busy && o_done) check({tag, "_excl"}, 32'd1, 32'd0);
    end
    check({tag, "_lat"}, lat, elat);
    check({tag, "_d"},   {24'b0, o_d},   {24'b0, ed});
    check({tag, "_bo"},  {31'b0, o_bo},  {31'b0, ebo});
    check({tag, "_ovf"}, {31'b0, o_ovf}, {31'b0, eovf});
    tick();
    check({tag, "_pulse"}, {30'b0, o_done, o_busy}, 32'd0);
    check({tag, "_hold"},  {24'b0, o_d}, {24'b0, ed});
  endtask

  initial begin
    int lat;
    int pulses;
    rst = 1'b1; start1 = 1'b0; start4 = 1'b0; sel = 1'b0;
    a = 8'h00; b = 8'h00; bin = 1'b0;
    tick();
    tick();
    check("rst1", {20'b0, busy1, done1, d1, bo1, ovf1}, 32'd0);
    check("rst4", {20'b0, busy4, done4, d4, bo4, ovf4}, 32'd0);
    rst = 1'b0;

    run_op(1'b0, 8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0, 8, "b1_35m12");
    run_op(1'b0, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 8, "b1_00m01");
    run_op(1'b0, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 8, "b1_80m01");
    run_op(1'b0, 8'h05, 8'h05, 1'b1, 8'hFF, 1'b1, 1'b0, 8, "b1_05m05b");

    // A start pulse with different operands during RUN must not disturb the operation.
    sel = 1'b0;
    a = 8'h35; b = 8'h12; bin = 1'b0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    a = 8'hFF; b = 8'hFF; bin = 1'b1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    lat = 2;
    while (!done1 && lat < 40) begin
      tick();
      lat++;
    end
    check("ign_lat", lat, 8);
    check("ign_d", {24'b0, d1}, 32'h23);
    tick();

    // Reset in RUN cycle 3 discards the operation and clears the result.
    a = 8'h80; b = 8'h01; bin = 1'b0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst", {20'b0, busy1, done1, d1, bo1, ovf1}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done1) pulses++;
    end
    check("mid_rst_nodone", pulses, 0);

    // Reset wins over start in the same cycle.
    rst = 1'b1; start1 = 1'b1;
    tick();
    rst = 1'b0; start1 = 1'b0;
    check("rst_prio", {31'b0, busy1}, 32'd0);

    run_op(1'b0, 8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0, 8, "b1_fresh");

    // Four bits per cycle, start held high across a back-to-back pair.
    sel = 1'b1;
    a = 8'h7F; b = 8'h80; bin = 1'b0;
    start4 = 1'b1;
    tick();
    check("b4_busy", {30'b0, busy4, done4}, 32'd2);
    a = 8'h10; b = 8'h01;
    tick();
    check("b4_run2", {30'b0, busy4, done4}, 32'd2);
    tick();
    check("b4_done", {30'b0, busy4, done4}, 32'd1);
    check("b4_d",    {24'b0, d4},  32'hFF);
    check("b4_bo",   {31'b0, bo4}, 32'd1);
    check("b4_ovf",  {31'b0, ovf4}, 32'd1);
    tick();
    start4 = 1'b0;
    check("b2b_busy", {30'b0, busy4, done4}, 32'd2);
    check("b2b_keep", {24'b0, d4}, 32'hFF);
    tick();
    check("b2b_run2", {30'b0, busy4, done4}, 32'd2);
    tick();
    check("b2b_done", {30'b0, busy4, done4}, 32'd1);
    check("b2b_d",    {24'b0, d4},  32'h0F);
    check("b2b_bo",   {31'b0, bo4}, 32'd0);
    check("b2b_ovf",  {31'b0, ovf4}, 32'd0);
    tick();
    check("b2b_idle", {30'b0, busy4, done4}, 32'd0);

    // Borrow-in must ripple across the nibble boundary through the borrow register.
    run_op(1'b1, 8'h10, 8'h00, 1'b1, 8'h0F, 1'b0, 1'b0, 2, "b4_binrip");
    run_op(1'b1, 8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0, 2, "b4_35m12");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
